// File: rtl/player_pixel_compositor.sv
// -----------------------------------------------------------------------------
// player_pixel_compositor
//
// Pixel-stage compositor that sits directly behind the player sprite-address
// generator. It forwards the sprite address to a synchronous sprite ROM,
// looks the returned encoded pixel up in a loadable palette, overlays opaque
// player pixels on the background colour and produces registered VGA RGB.
// It also owns the post-hit invulnerability blink state machine, because
// blinking is only a visibility decision at this point of the pipeline.
//
// Pipeline (fixed latency of two cycles, never stalls):
//   cycle t   : playerOn / spriteAddress / bgColor presented, romAddr driven
//   cycle t+1 : on_d1 / bg_d1 hold cycle-t inputs, romData holds ROM[t]
//   cycle t+2 : Red/Green/Blue hold the composited pixel
//
// Optional feature (macro COLLISION_DETECT_EN):
//   When defined, enemyOn is delayed alongside playerOn and a per-frame
//   collision flag is produced. When undefined, enemyOn is ignored and
//   collision is tied low; the port list is the same in both builds.
//
// Ports:
//   frame_Clk      in   1        pixel/system clock
//   Reset          in   1        synchronous, active-high reset
//   playerOn       in   1        player bounding-box hit for current pixel
//   spriteAddress  in   ADDR_W   sprite ROM address for current pixel
//   bgColor        in   24       background {R,G,B}, aligned with playerOn
//   vsync_pulse    in   1        one-cycle pulse once per frame
//   hit            in   1        one-cycle damage pulse
//   romAddr        out  ADDR_W   address to synchronous sprite ROM
//   romData        in   IDX_W    ROM data, valid one cycle after romAddr
//   pal_we         in   1        palette write enable
//   pal_waddr      in   IDX_W    palette write index
//   pal_wdata      in   24       palette write data {R,G,B}
//   Red/Green/Blue out  8 each   composited pixel, registered
//   invuln         out  1        high while the blink FSM is in INVULN
//   enemyOn        in   1        enemy pixel opaque (collision build only)
//   collision      out  1        per-frame collision flag (collision build only)
// -----------------------------------------------------------------------------
module player_pixel_compositor #(
   parameter int ADDR_W          = 21,
   parameter int IDX_W           = 4,
   parameter int TRANSPARENT_IDX = 0,
   parameter int BLINK_FRAMES    = 60,
   parameter int BLINK_PERIOD    = 4
) (
   input  logic              frame_Clk,
   input  logic              Reset,
   input  logic              playerOn,
   input  logic [ADDR_W-1:0] spriteAddress,
   input  logic [23:0]       bgColor,
   input  logic              vsync_pulse,
   input  logic              hit,
   output logic [ADDR_W-1:0] romAddr,
   input  logic [IDX_W-1:0]  romData,
   input  logic              pal_we,
   input  logic [IDX_W-1:0]  pal_waddr,
   input  logic [23:0]       pal_wdata,
   output logic [7:0]        Red,
   output logic [7:0]        Green,
   output logic [7:0]        Blue,
   output logic              invuln,
   input  logic              enemyOn,
   output logic              collision
);

   localparam int               PAL_N       = 1 << IDX_W;
   localparam logic [IDX_W-1:0] TRANSP_IDX  = IDX_W'(TRANSPARENT_IDX);
   localparam logic [7:0]       FRAMES_INIT = 8'(BLINK_FRAMES);
   localparam logic [3:0]       PERIOD_LAST = 4'(BLINK_PERIOD - 1);

   // ------------------------------------------------------------------
   // Sprite ROM address: straight pass-through so the ROM's own output
   // register supplies the first pipeline stage of the pixel index.
   // ------------------------------------------------------------------
   assign romAddr = spriteAddress;

   // ------------------------------------------------------------------
   // Palette: one register per entry so the whole table can be cleared by
   // Reset. The read is combinational into the RGB register, so a write in
   // the same cycle as a read of that entry still yields the old colour.
   // ------------------------------------------------------------------
   logic [23:0] pal_rd [PAL_N];
   logic [23:0] pal_rdata;

   genvar gi;
   generate
      for (gi = 0; gi < PAL_N; gi++) begin : g_pal
         logic [23:0] entry_reg;

         always_ff @(posedge frame_Clk) begin
            if (Reset) begin
               entry_reg <= '0;
            end else if (pal_we && (pal_waddr == IDX_W'(gi))) begin
               entry_reg <= pal_wdata;
            end
         end

         assign pal_rd[gi] = entry_reg;
      end
   endgenerate

   assign pal_rdata = pal_rd[romData];

   // ------------------------------------------------------------------
   // Stage 1: align playerOn / bgColor with the ROM output.
   // ------------------------------------------------------------------
   logic        on_d1;
   logic [23:0] bg_d1;

   always_ff @(posedge frame_Clk) begin
      if (Reset) begin
         on_d1 <= 1'b0;
         bg_d1 <= '0;
      end else begin
         on_d1 <= playerOn;
         bg_d1 <= bgColor;
      end
   end

   // ------------------------------------------------------------------
   // Blink FSM. frames_left counts remaining frames of invulnerability;
   // phase_cnt counts frames inside the current visible/hidden half-phase
   // and phase selects which half we are in (0 = visible).
   // ------------------------------------------------------------------
   typedef enum logic {
      NORMAL = 1'b0,
      INVULN = 1'b1
   } blink_state_t;

   blink_state_t state_reg, state_next;
   logic [7:0]   frames_left_reg, frames_left_next;
   logic [3:0]   phase_cnt_reg, phase_cnt_next;
   logic         phase_reg, phase_next;
   logic         visible;

   always_ff @(posedge frame_Clk) begin
      if (Reset) begin
         state_reg       <= NORMAL;
         frames_left_reg <= '0;
         phase_cnt_reg   <= '0;
         phase_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         frames_left_reg <= frames_left_next;
         phase_cnt_reg   <= phase_cnt_next;
         phase_reg       <= phase_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      frames_left_next = frames_left_reg;
      phase_cnt_next   = phase_cnt_reg;
      phase_next       = phase_reg;

      case (state_reg)
         NORMAL: begin
            // A vsync in the same cycle as the hit is deliberately not
            // counted: the full blink duration starts after the hit.
            if (hit) begin
               state_next       = INVULN;
               frames_left_next = FRAMES_INIT;
               phase_cnt_next   = '0;
               phase_next       = 1'b0;
            end
         end

         INVULN: begin
            // Hits are ignored here: no retrigger, no extension.
            if (vsync_pulse) begin
               frames_left_next = frames_left_reg - 8'd1;

               if (phase_cnt_reg == PERIOD_LAST) begin
                  phase_cnt_next = '0;
                  phase_next     = ~phase_reg;
               end else begin
                  phase_cnt_next = phase_cnt_reg + 4'd1;
               end

               if (frames_left_reg == 8'd1) begin
                  state_next     = NORMAL;
                  phase_cnt_next = '0;
                  phase_next     = 1'b0;
               end
            end
         end

         default: begin
            state_next = NORMAL;
         end
      endcase
   end

   // State only moves on clock edges and phase only on vsync, so visibility
   // changes exclusively at frame boundaries.
   assign visible = (state_reg == NORMAL) || !phase_reg;
   assign invuln  = (state_reg == INVULN);

   // ------------------------------------------------------------------
   // Stage 2: composite and register the output colour.
   // ------------------------------------------------------------------
   logic        opaque;
   logic [23:0] rgb_reg;

   assign opaque = on_d1 && (romData != TRANSP_IDX) && visible;

   always_ff @(posedge frame_Clk) begin
      if (Reset) begin
         rgb_reg <= '0;
      end else begin
         rgb_reg <= opaque ? pal_rdata : bg_d1;
      end
   end

   assign Red   = rgb_reg[23:16];
   assign Green = rgb_reg[15:8];
   assign Blue  = rgb_reg[7:0];

   // ------------------------------------------------------------------
   // Optional collision detection.
   // ------------------------------------------------------------------
`ifdef COLLISION_DETECT_EN
   logic enemy_d1;
   logic sticky_reg;
   logic collision_reg;
   logic coll_set;

   // Uses the blink-qualified opaque, so hidden pixels never collide.
   assign coll_set = opaque && enemy_d1;

   always_ff @(posedge frame_Clk) begin
      if (Reset) begin
         enemy_d1      <= 1'b0;
         sticky_reg    <= 1'b0;
         collision_reg <= 1'b0;
      end else begin
         enemy_d1 <= enemyOn;
         if (vsync_pulse) begin
            // A set landing on the vsync cycle still counts for the frame
            // that is closing.
            collision_reg <= sticky_reg | coll_set;
            sticky_reg    <= 1'b0;
         end else if (coll_set) begin
            sticky_reg <= 1'b1;
         end
      end
   end

   assign collision = collision_reg;
`else
   logic enemy_unused;

   assign enemy_unused = enemyOn;
   assign collision    = 1'b0;
`endif

endmodule

// File: tb/tb_player_pixel_compositor.sv
// -----------------------------------------------------------------------------
// tb_player_pixel_compositor
//
// Self-checking bench for player_pixel_compositor. A small synchronous ROM
// model feeds romData. A behavioural reference model tracks the palette, the
// invulnerability window as "frames since hit" and the per-frame collision
// flag, and predicts RGB / invuln / collision after every clock edge.
// Directed sequences cover latency, transparency, palette write ordering,
// blink timing and reset; a randomized section follows.
// -----------------------------------------------------------------------------
module tb_player_pixel_compositor;

   localparam int ADDR_W    = 21;
   localparam int IDX_W     = 4;
   localparam int BF        = 8;
   localparam int BP        = 2;
   localparam int FRAME_LEN = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              player_on;
   logic [ADDR_W-1:0] sprite_addr;
   logic [23:0]       bg_color;
   logic              vsync;
   logic              hit;
   logic [ADDR_W-1:0] rom_addr;
   logic [IDX_W-1:0]  rom_data;
   logic              pal_we;
   logic [IDX_W-1:0]  pal_waddr;
   logic [23:0]       pal_wdata;
   logic [7:0]        red, green, blue;
   logic              invuln;
   logic              enemy_on;
   logic              collision;

   always #5 clk = ~clk;

   player_pixel_compositor #(
      .ADDR_W(ADDR_W),
      .IDX_W(IDX_W),
      .TRANSPARENT_IDX(0),
      .BLINK_FRAMES(BF),
      .BLINK_PERIOD(BP)
   ) dut (
      .frame_Clk(clk),
      .Reset(rst),
      .playerOn(player_on),
      .spriteAddress(sprite_addr),
      .bgColor(bg_color),
      .vsync_pulse(vsync),
      .hit(hit),
      .romAddr(rom_addr),
      .romData(rom_data),
      .pal_we(pal_we),
      .pal_waddr(pal_waddr),
      .pal_wdata(pal_wdata),
      .Red(red),
      .Green(green),
      .Blue(blue),
      .invuln(invuln),
      .enemyOn(enemy_on),
      .collision(collision)
   );

   // Synchronous sprite ROM: data one cycle after address.
   logic [3:0] rom_mem [64];
   always @(posedge clk) rom_data <= rom_mem[rom_addr[5:0]];

   // ------------------------------------------------------------------
   // Reference model state
   // ------------------------------------------------------------------
   typedef struct packed {
      logic        on;
      logic [5:0]  addr;
      logic [23:0] bg;
      logic        enemy;
   } px_t;

   logic [23:0] m_pal [16];
   px_t         m_prev;
   logic [23:0] m_rgb;
   logic        m_inv;
   int          m_frames;
   logic        m_coll;
`ifdef COLLISION_DETECT_EN
   logic        m_acc;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: predict from the inputs currently applied, advance
   // the clock, then compare outputs 1 time unit after the edge.
   task automatic cycle();
      px_t        cur;
      logic [3:0] idx;
      logic       vis;
      logic       opq;
      check("romAddr", 32'(rom_addr), 32'(sprite_addr));
      cur.on    = player_on;
      cur.addr  = sprite_addr[5:0];
      cur.bg    = bg_color;
      cur.enemy = enemy_on;
      if (rst) begin
         m_rgb    = '0;
         m_prev   = '0;
         for (int i = 0; i < 16; i++) m_pal[i] = '0;
         m_inv    = 1'b0;
         m_frames = 0;
         m_coll   = 1'b0;
`ifdef COLLISION_DETECT_EN
         m_acc    = 1'b0;
`endif
      end else begin
         vis   = !m_inv || (((m_frames / BP) % 2) == 0);
         idx   = rom_mem[m_prev.addr];
         opq   = m_prev.on && (idx != 4'd0) && vis;
         m_rgb = opq ? m_pal[idx] : m_prev.bg;
`ifdef COLLISION_DETECT_EN
         if (vsync) begin
            m_coll = m_acc | (opq & m_prev.enemy);
            m_acc  = 1'b0;
         end else begin
            m_acc = m_acc | (opq & m_prev.enemy);
         end
`endif
         if (pal_we) m_pal[pal_waddr] = pal_wdata;
         if (!m_inv) begin
            if (hit) begin
               m_inv    = 1'b1;
               m_frames = 0;
            end
         end else if (vsync) begin
            m_frames++;
            if (m_frames == BF) m_inv = 1'b0;
         end
         m_prev = cur;
      end
      @(posedge clk);
      #1;
      check("rgb", {8'h00, red, green, blue}, {8'h00, m_rgb});
      check("invuln", 32'(invuln), 32'(m_inv));
      check("collision", 32'(collision), 32'(m_coll));
   endtask

   task automatic idle();
      player_on = 1'b0;
      bg_color  = '0;
      enemy_on  = 1'b0;
      hit       = 1'b0;
      vsync     = 1'b0;
      pal_we    = 1'b0;
   endtask

   task automatic pal_write(input logic [3:0] idx, input logic [23:0] data);
      idle();
      pal_we    = 1'b1;
      pal_waddr = idx;
      pal_wdata = data;
      $display("palette write idx %0d = %h", idx, data);
      cycle();
      pal_we = 1'b0;
   endtask

   // One frame of opaque player pixels (ROM index 3) over blue background,
   // vsync on the last cycle.
   task automatic run_frame(input int hit_pos, input bit enemy,
                            output logic [23:0] rgb_mid, output logic inv_first);
      rgb_mid   = '0;
      inv_first = 1'b0;
      for (int c = 0; c < FRAME_LEN; c++) begin
         player_on   = 1'b1;
         sprite_addr = 21'd1;
         bg_color    = 24'h0000FF;
         enemy_on    = enemy && (c == 2);
         hit         = (c == hit_pos);
         vsync       = (c == FRAME_LEN - 1);
         cycle();
         if (c == 0) inv_first = invuln;
         if (c == 2) rgb_mid = {red, green, blue};
      end
      hit      = 1'b0;
      vsync    = 1'b0;
      enemy_on = 1'b0;
   endtask

   task automatic blink_seq(input int extra_hit_frame, input bit hit_on_vsync);
      logic [23:0] mid;
      logic        inv1;
      $display("blink sequence: extra hit frame %0d, hit on vsync %0d", extra_hit_frame, hit_on_vsync);
      if (hit_on_vsync) begin
         run_frame(FRAME_LEN - 1, 1'b0, mid, inv1);
         check("hitvs_enter", 32'(invuln), 32'd1);
      end
      for (int j = 1; j <= BF; j++) begin
         int hp;
         hp = -1;
         if (!hit_on_vsync && j == 1) hp = 0;
         if (j == extra_hit_frame) hp = 0;
         run_frame(hp, 1'b0, mid, inv1);
         if (!hit_on_vsync && j == 1) check("hit_enter", 32'(inv1), 32'd1);
         check("blink_vis", 32'(mid), (((j - 1) / BP) % 2 == 0) ? 32'h00FF8000 : 32'h000000FF);
         check("blink_exit", 32'(invuln), (j < BF) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      logic [23:0] mid;
      logic        inv1;
      logic [31:0] coll_exp;

      rst         = 1'b1;
      sprite_addr = '0;
      pal_waddr   = '0;
      pal_wdata   = '0;
      idle();
      for (int a = 0; a < 64; a++) rom_mem[a] = 4'($urandom_range(0, 15));
      rom_mem[1] = 4'd3;
      rom_mem[2] = 4'd0;
      rom_mem[5] = 4'd5;
      for (int i = 0; i < 16; i++) rom_mem[16 + i] = 4'(i);

`ifdef COLLISION_DETECT_EN
      coll_exp = 32'd1;
`else
      coll_exp = 32'd0;
`endif

      // Reset state
      repeat (3) cycle();
      check("reset_rgb", {8'h00, red, green, blue}, 32'd0);
      check("reset_invuln", 32'(invuln), 32'd0);
      check("reset_collision", 32'(collision), 32'd0);
      rst = 1'b0;
      cycle();

      // Opaque pixel, two-cycle latency
      pal_write(4'd3, 24'hFF8000);
      player_on = 1'b1; sprite_addr = 21'd1; bg_color = 24'h0000FF;
      cycle();
      check("lat1_rgb", {8'h00, red, green, blue}, 32'd0);
      idle();
      cycle();
      check("lat2_rgb", {8'h00, red, green, blue}, 32'h00FF8000);
      $display("latency transaction done");

      // Transparent index, then playerOn low
      player_on = 1'b1; sprite_addr = 21'd2; bg_color = 24'h102030;
      cycle();
      player_on = 1'b0; sprite_addr = 21'd5; bg_color = 24'h405060;
      cycle();
      check("transp_rgb", {8'h00, red, green, blue}, 32'h00102030);
      idle();
      cycle();
      check("off_rgb", {8'h00, red, green, blue}, 32'h00405060);
      $display("transparency transaction done");

      // Same-cycle palette write returns the old colour, then the new one
      player_on = 1'b1; sprite_addr = 21'd1; bg_color = 24'h0000FF;
      cycle();
      idle();
      pal_we = 1'b1; pal_waddr = 4'd3; pal_wdata = 24'h123456;
      cycle();
      check("wr_old_rgb", {8'h00, red, green, blue}, 32'h00FF8000);
      pal_we = 1'b0;
      player_on = 1'b1; sprite_addr = 21'd1; bg_color = 24'h0000FF;
      cycle();
      idle();
      cycle();
      check("wr_new_rgb", {8'h00, red, green, blue}, 32'h00123456);
      pal_write(4'd3, 24'hFF8000);
      for (int i = 1; i < 16; i++) begin
         if (i != 3) pal_write(4'(i), 24'($urandom) | 24'h010101);
      end

      // Blink timing
      blink_seq(0, 1'b0);
      blink_seq(3, 1'b0);
      blink_seq(0, 1'b1);

      // Collision while visible, then while blink-hidden
      idle(); cycle();
      run_frame(-1, 1'b0, mid, inv1);
      run_frame(-1, 1'b1, mid, inv1);
      check("coll_set", 32'(collision), coll_exp);
      run_frame(-1, 1'b0, mid, inv1);
      check("coll_clear", 32'(collision), 32'd0);
      run_frame(0, 1'b0, mid, inv1);
      run_frame(-1, 1'b0, mid, inv1);
      run_frame(-1, 1'b1, mid, inv1);
      check("coll_hidden", 32'(collision), 32'd0);
      for (int j = 4; j <= BF; j++) run_frame(-1, 1'b0, mid, inv1);
      check("coll_blink_exit", 32'(invuln), 32'd0);
      $display("collision transaction done");

      // Reset mid-blink with opaque pixels streaming
      run_frame(0, 1'b0, mid, inv1);
      run_frame(-1, 1'b0, mid, inv1);
      run_frame(-1, 1'b0, mid, inv1);
      player_on = 1'b1; sprite_addr = 21'd1; bg_color = 24'h0000FF;
      rst = 1'b1;
      cycle();
      check("rst_mid_rgb", {8'h00, red, green, blue}, 32'd0);
      check("rst_mid_invuln", 32'(invuln), 32'd0);
      rst = 1'b0;
      idle();
      cycle();
      for (int i = 1; i < 16; i++) begin
         player_on = 1'b1; sprite_addr = 21'(16 + i); bg_color = 24'hABCDEF;
         cycle();
         idle();
         cycle();
         check("pal_cleared", {8'h00, red, green, blue}, 32'd0);
      end
      $display("reset mid-blink transaction done");

      // Randomized traffic
      for (int k = 0; k < 2400; k++) begin
         player_on   = ($urandom_range(0, 9) < 7);
         sprite_addr = 21'($urandom);
         bg_color    = 24'($urandom);
         enemy_on    = 1'($urandom_range(0, 1));
         pal_we      = ($urandom_range(0, 9) == 0);
         pal_waddr   = 4'($urandom);
         pal_wdata   = 24'($urandom);
         vsync       = ((k % 12) == 11);
         hit         = ($urandom_range(0, 149) == 0);
         rst         = ($urandom_range(0, 599) == 0);
         if (hit) $display("random hit at cycle %0d", k);
         if (rst) $display("random reset at cycle %0d", k);
         cycle();
      end
      rst = 1'b0;
      idle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
